// File: rtl/stream_arbiter_2.sv
// Two-input round-robin stream arbiter with bounded bursts and one output register.
// Optional STREAM_ARB_TAG_EN adds out_src, the source index of the held beat.
module stream_arbiter_2 #(
  parameter int unsigned N     = 8,
  parameter int unsigned BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [N-1:0] in0_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  input  logic [N-1:0] in1_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [1:0]   grant
`ifdef STREAM_ARB_TAG_EN
  ,
  output logic         out_src
`endif
);

  localparam int unsigned CW = $clog2(BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_G0   = 2'd1,
    S_G1   = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_rr;
  logic            w_rr_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_out_valid;
  logic [N-1:0]    r_out_data;
  logic            w_room;
  logic            w_acc0;
  logic            w_acc1;
  logic            w_last;

  // Output register can take a beat when empty or draining this edge.
  assign w_room    = !r_out_valid || out_ready;
  assign in0_ready = (r_state == S_G0) && w_room;
  assign in1_ready = (r_state == S_G1) && w_room;
  assign w_acc0    = in0_valid && in0_ready;
  assign w_acc1    = in1_valid && in1_ready;
  assign w_last    = (r_cnt == CW'(BURST - 1));

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign grant     = {r_state == S_G1, r_state == S_G0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_rr    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rr    <= w_rr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rr_nxt    = r_rr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (in0_valid && (!in1_valid || !r_rr)) begin
          w_state_nxt = S_G0;
        end else if (in1_valid) begin
          w_state_nxt = S_G1;
        end
      end
      S_G0: begin
        if (w_acc0) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
        if (!in0_valid || (w_acc0 && w_last)) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = 1'b1;
        end
      end
      S_G1: begin
        if (w_acc1) begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
        if (!in1_valid || (w_acc1 && w_last)) begin
          w_state_nxt = S_IDLE;
          w_rr_nxt    = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Load on accept; a drain without a load empties the register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_acc0 || w_acc1) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_acc1 ? in1_data : in0_data;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef STREAM_ARB_TAG_EN
  logic r_out_src;
  assign out_src = r_out_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_src <= 1'b0;
    end else if (w_acc0 || w_acc1) begin
      r_out_src <= w_acc1;
    end
  end
`endif

endmodule

// File: doc/stream_arbiter_2.md
# stream_arbiter_2

Two-input round-robin arbiter that shares one downstream stream primitive (such as an `ap01`/`ap02` stream stage) between two upstream stream producers. It grants one input at a time for a bounded burst of beats and forwards the accepted beats through a single output register with valid/ready flow control. The block sits between generated stream producers and a shared stream consumer, and is clocked by the same `clk` as the primitives.

## Interface
Parameters:
- `N`, default 8: data width in bits. Matches `intN`.
- `BURST`, default 4: maximum beats per grant. Must be ≥1.

Ports:
- `clk`, input, 1: the single clock. All state changes on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `in0_valid`, input, 1: requester 0 has a beat.
- `in0_ready`, output, 1: requester 0 beat accepted this cycle (when `in0_valid` is also high).
- `in0_data`, input, N: requester 0 payload.
- `in1_valid`, `in1_ready`, `in1_data`: same as the three ports above, for requester 1.
- `out_valid`, output, 1: output register holds a beat.
- `out_ready`, input, 1: consumer accepts the beat.
- `out_data`, output, N: output payload.
- `grant`, output, 2: one-hot current grant. `2'b00` means IDLE.
- `out_src`, output, 1: source of the current output beat. Present only with `STREAM_ARB_TAG_EN`.

## Operation
- Transfer rule: a beat moves on any edge where `inX_valid && inX_ready`. The output beat leaves on any edge where `out_valid && out_ready`.
- `inX_ready` is asserted only when all of the following hold:
  - state is GX;
  - `!out_valid || out_ready`.
  - The non-granted input's ready is always 0, and both readies are 0 in IDLE.
- FSM states:
  - IDLE → GX when at least one input is valid.
    - If both inputs are valid, the input selected by round-robin pointer `rr` wins.
    - If only one input is valid, that input wins.
    - No transfer occurs in the IDLE cycle.
  - GX → IDLE on the edge that completes the BURST-th transfer of the grant.
  - GX → IDLE on any edge where `inX_valid`=0. A stalled consumer with `inX_valid`=1 keeps the grant.
  - Leaving GX sets `rr` to point at the other input.
- Burst counter:
  - Width is `$clog2(BURST+1)`.
  - Cleared on entry to GX.
  - Incremented per accepted beat.
  - Saturation is not needed because exit occurs at BURST.
- Output register:
  - Loads `inX_data` on each accepted beat and sets `out_valid`.
  - Clears `out_valid` when the beat drains with no new load on that edge.
  - Simultaneous drain and load keeps `out_valid`=1 and replaces the data.
  - Data and valid stay stable while `out_valid && !out_ready`. Valid never retracts.
- Fairness: with both inputs continuously valid and `out_ready`=1, grants alternate 0,1,0,1…, each for BURST beats.
- Reset:
  - State → IDLE.
  - `rr` → input 0.
  - `out_valid`=0, `out_data`=0, `grant`=0, both readies 0, counter 0.
  - A reset mid-burst discards the output register beat and any in-flight beats with no handshake.

## Timing
- Arbitration latency: a request first seen in IDLE at edge t gives grant visible after t. The first accept is at edge t+1, and `out_valid` is high after t+1.
- Datapath latency: 1 cycle from input accept to `out_valid`.
- Throughput: 1 beat/cycle within a burst. There is exactly one bubble cycle (IDLE) between grants, so sustained efficiency is BURST/(BURST+1).
- `inX_ready` is combinational from `out_ready`, state and `out_valid`. There is no combinational path from `inX_valid` to any ready.

## Configuration
- `STREAM_ARB_TAG_EN` defined:
  - Adds the `out_src` output.
  - `out_src` is registered alongside `out_data` and equals the granted index of the loaded beat.
  - Its reset value is 0.
- `STREAM_ARB_TAG_EN` undefined:
  - The port and its flop do not exist.
  - All other behaviour is identical.

## Test plan
- Reset mid-burst:
  - Stimulus: assert `rst` asynchronously between edges with `out_valid`=1.
  - Response: outputs go to 0 immediately, without waiting for an edge. After release, the first grant goes to input 0 when both are valid.
- Single requester:
  - Stimulus: `in0` valid with data 1,2,3; `out_ready`=1; BURST=4.
  - Response: `grant`=01 one cycle after the request. `out_data` shows 1,2,3 on consecutive cycles. Return to IDLE when `in0_valid` drops.
- Contention:
  - Stimulus: both inputs always valid (`in0`: 10,11,…; `in1`: 20,21,…), `out_ready`=1, BURST=4.
  - Response: output is 10–13, then one bubble, then 20–23, then one bubble, then 14–17.
- Backpressure:
  - Stimulus: `out_ready`=0 for 3 cycles while `out_valid`=1 holding 10.
  - Response: `out_data` is stable at 10 and `in0_ready`=0. After release, 11 follows with no loss or duplication.
- BURST=1:
  - Stimulus: both inputs valid.
  - Response: grants alternate every beat, giving the pattern beat, bubble, beat from the other input.
- Tag build, with `STREAM_ARB_TAG_EN` defined:
  - Stimulus: repeat the contention case.
  - Response: `out_src` is 0 for values 10–13 and 1 for values 20–23.
